fetch_queue: RTL and testbench



---
 rtl/fetch_queue_if.sv | 20 ++
 rtl/fetch_queue.sv | 69 ++++++
 tb/tb_fetch_queue.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-to-memory and fetch-to-decode signal bundle.
// master: the fetch queue (drives imem_addr and the decode-side head entry).
// slave: the environment (memory word, redirect request, decode ready).
// Macro FETCH_STATS_EN adds fetch_count/flush_count to both modports.
interface fetch_queue_if;
  logic [31:0] imem_addr, imem_instr, redirect_pc, instr, instr_pc;
  logic redirect_valid, instr_valid, instr_ready;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count, flush_count;
  modport master (output imem_addr, instr_valid, instr, instr_pc, fetch_count, flush_count,
                  input imem_instr, redirect_valid, redirect_pc, instr_ready);
  modport slave (input imem_addr, instr_valid, instr, instr_pc, fetch_count, flush_count,
                 output imem_instr, redirect_valid, redirect_pc, instr_ready);
`else
  modport master (output imem_addr, instr_valid, instr, instr_pc,
                  input imem_instr, redirect_valid, redirect_pc, instr_ready);
  modport slave (input imem_addr, instr_valid, instr, instr_pc,
                 output imem_instr, redirect_valid, redirect_pc, instr_ready);
`endif
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: PC owner and prefetch FIFO between instruction memory and decode.
// Ports: clk, rst (sync active-high), f (fetch_queue_if.master: imem_addr/imem_instr,
// redirect_valid/redirect_pc, instr_valid/instr_ready/instr/instr_pc).
// Macro FETCH_STATS_EN adds fetch_count (pushes) and flush_count (discarding redirects).
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic clk,
  input logic rst,
  fetch_queue_if.master f
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc_q [DEPTH];
  logic [31:0] ins_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic pop, push;
  always_comb begin
    pop = (count_q != '0) & f.instr_ready;
    push = !f.redirect_valid & ((count_q != CW'(DEPTH)) | pop);
    fetch_pc_d = f.redirect_valid ? {f.redirect_pc[31:2], 2'b00} : push ? fetch_pc_q + 32'd4 : fetch_pc_q;
    rd_ptr_d = f.redirect_valid ? '0 : pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = f.redirect_valid ? '0 : push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d = f.redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i] <= '0;
        ins_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
      if (push) begin
        pc_q[wr_ptr_q] <= fetch_pc_q;
        ins_q[wr_ptr_q] <= f.imem_instr;
      end
    end
  end
  assign f.imem_addr = fetch_pc_q;
  assign f.instr_valid = count_q != '0;
  assign f.instr = ins_q[rd_ptr_q];
  assign f.instr_pc = pc_q[rd_ptr_q];
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_q, flush_count_q;
  // a redirect only counts as a flush when something beyond the popped head is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_q + 32'(push);
      flush_count_q <= flush_count_q + 32'(f.redirect_valid & (count_q > CW'(pop)));
    end
  end
  assign f.fetch_count = fetch_count_q;
  assign f.flush_count = flush_count_q;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue (DEPTH=4, RESET_PC=0).
module tb_fetch_queue;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  fetch_queue_if fi ();
  fetch_queue dut (.clk(clk), .rst(rst), .f(fi.master));
  always #5 clk = ~clk;
  always_comb fi.imem_instr = 32'(fi.imem_addr[7:2]) + 32'd100;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fi.redirect_valid = 1'b0;
    fi.redirect_pc = '0;
    fi.instr_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fi.redirect_valid = 1'b1;
    fi.redirect_pc = 32'h0000_0080;
    fi.instr_ready = 1'b1;
    step();
    step();
    checks++; if (fi.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d exp 0", fi.instr_valid); end
    checks++; if (fi.instr !== 32'd0) begin errors++; $display("FAIL reset_instr got %h exp 0", fi.instr); end
    checks++; if (fi.instr_pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %h exp 0", fi.instr_pc); end
    checks++; if (fi.imem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr got %h exp 0", fi.imem_addr); end
`ifdef FETCH_STATS_EN
    checks++; if (fi.fetch_count !== 32'd0 || fi.flush_count !== 32'd0) begin errors++; $display("FAIL reset_stats got %0d/%0d exp 0/0", fi.fetch_count, fi.flush_count); end
`endif
  endtask

  task automatic test_stream();
    do_reset();
    fi.instr_ready = 1'b1;
    checks++; if (fi.instr_valid !== 1'b0) begin errors++; $display("FAIL stream_first_valid got %0d exp 0", fi.instr_valid); end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (fi.instr_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0d exp 1", k, fi.instr_valid); end
      checks++; if (fi.instr_pc !== 32'(4 * k)) begin errors++; $display("FAIL stream_pc[%0d] got %h exp %h", k, fi.instr_pc, 32'(4 * k)); end
      checks++; if (fi.instr !== 32'(100 + k)) begin errors++; $display("FAIL stream_instr[%0d] got %0d exp %0d", k, fi.instr, 100 + k); end
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 0; k < 8; k++) step();
    checks++; if (fi.imem_addr !== 32'd16) begin errors++; $display("FAIL full_addr got %h exp 10", fi.imem_addr); end
    checks++; if (fi.instr_valid !== 1'b1 || fi.instr_pc !== 32'd0) begin errors++; $display("FAIL full_head got %0d/%h exp 1/0", fi.instr_valid, fi.instr_pc); end
    fi.instr_ready = 1'b1;
    step();
    fi.instr_ready = 1'b0;
    checks++; if (fi.imem_addr !== 32'd20) begin errors++; $display("FAIL full_pop_push_addr got %h exp 14", fi.imem_addr); end
    checks++; if (fi.instr_pc !== 32'd4) begin errors++; $display("FAIL full_pop_head got %h exp 4", fi.instr_pc); end
    step();
    checks++; if (fi.instr_pc !== 32'd4 || fi.imem_addr !== 32'd20) begin errors++; $display("FAIL full_hold got %h/%h exp 4/14", fi.instr_pc, fi.imem_addr); end
    fi.instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (fi.instr_pc !== 32'(8 + 4 * k) || fi.instr !== 32'(102 + k)) begin errors++; $display("FAIL full_drain[%0d] got %h/%0d exp %h/%0d", k, fi.instr_pc, fi.instr, 8 + 4 * k, 102 + k); end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int k = 0; k < 3; k++) step();
    fi.redirect_valid = 1'b1;
    fi.redirect_pc = 32'h0000_0042;
    step();
    fi.redirect_valid = 1'b0;
    checks++; if (fi.instr_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %0d exp 0", fi.instr_valid); end
    checks++; if (fi.imem_addr !== 32'h40) begin errors++; $display("FAIL redir_addr got %h exp 40", fi.imem_addr); end
`ifdef FETCH_STATS_EN
    checks++; if (fi.flush_count !== 32'd1) begin errors++; $display("FAIL redir_flush_count got %0d exp 1", fi.flush_count); end
`endif
    step();
    checks++; if (fi.instr_valid !== 1'b1 || fi.instr_pc !== 32'h40 || fi.instr !== 32'd116) begin errors++; $display("FAIL redir_target got %0d/%h/%0d exp 1/40/116", fi.instr_valid, fi.instr_pc, fi.instr); end
`ifdef FETCH_STATS_EN
    checks++; if (fi.fetch_count !== 32'd4) begin errors++; $display("FAIL redir_fetch_count got %0d exp 4", fi.fetch_count); end
`endif
  endtask

  task automatic test_wrap();
    fi.instr_ready = 1'b1;
    fi.redirect_valid = 1'b1;
    fi.redirect_pc = 32'hFFFF_FFFF;
    step();
    fi.redirect_valid = 1'b0;
    checks++; if (fi.imem_addr !== 32'hFFFF_FFFC || fi.instr_valid !== 1'b0) begin errors++; $display("FAIL wrap_addr got %h/%0d exp fffffffc/0", fi.imem_addr, fi.instr_valid); end
    step();
    checks++; if (fi.instr_pc !== 32'hFFFF_FFFC || fi.instr !== 32'd163) begin errors++; $display("FAIL wrap_first got %h/%0d exp fffffffc/163", fi.instr_pc, fi.instr); end
    checks++; if (fi.imem_addr !== 32'd0) begin errors++; $display("FAIL wrap_addr_zero got %h exp 0", fi.imem_addr); end
    step();
    checks++; if (fi.instr_pc !== 32'd0 || fi.instr !== 32'd100 || fi.instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_second got %h/%0d exp 0/100", fi.instr_pc, fi.instr); end
  endtask

  task automatic test_rst_override();
    fi.instr_ready = 1'b0;
    step();
    step();
    rst = 1'b1;
    fi.redirect_valid = 1'b1;
    fi.redirect_pc = 32'h0000_0100;
    fi.instr_ready = 1'b1;
    step();
    checks++; if (fi.instr_valid !== 1'b0 || fi.imem_addr !== 32'd0) begin errors++; $display("FAIL rst_override got %0d/%h exp 0/0", fi.instr_valid, fi.imem_addr); end
    checks++; if (fi.instr_pc !== 32'd0 || fi.instr !== 32'd0) begin errors++; $display("FAIL rst_override_head got %h/%h exp 0/0", fi.instr_pc, fi.instr); end
`ifdef FETCH_STATS_EN
    checks++; if (fi.fetch_count !== 32'd0 || fi.flush_count !== 32'd0) begin errors++; $display("FAIL rst_override_stats got %0d/%0d exp 0/0", fi.fetch_count, fi.flush_count); end
`endif
    rst = 1'b0;
    fi.redirect_valid = 1'b0;
    step();
    checks++; if (fi.instr_valid !== 1'b1 || fi.instr_pc !== 32'd0 || fi.imem_addr !== 32'd4) begin errors++; $display("FAIL rst_restart got %0d/%h/%h exp 1/0/4", fi.instr_valid, fi.instr_pc, fi.imem_addr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_wrap();
    test_rst_override();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
